carregador_programa: RTL
========================

Name: carregador_programa

Overview:
- Boot-time program loader that sits directly upstream of the nRISC core and its instruction memory.
- Receives a length-prefixed byte stream over a valid/ready handshake and writes each payload byte to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset until the load completes successfully, then releases it so execution starts at PC 0.

Parameters:
- TIMEOUT, 1000, max idle cycles between accepted bytes during a load; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- in_valid  in  1  producer has a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  8  write address
- mem_data  out  8  write data
- cpu_reset  out  1  active-high reset driven to the core
- busy  out  1  a load is in progress
- done  out  1  load finished successfully
- error  out  1  load aborted (timeout or checksum)

Behaviour:
- Single clock CLK; RESET is synchronous and active-high.
- RESET response: state IDLE; cpu_reset=1; in_ready, mem_we, busy, done, error all 0; mem_addr and mem_data 0; counters 0.
- Transfer rule: a byte transfers on any rising edge with in_valid & in_ready. in_ready depends only on state, never on in_valid.
- States: IDLE, LEN, LOAD, CHK (only with the optional feature), FLUSH, DONE, ERR.
- IDLE: cpu_reset=1, in_ready=0. start -> LEN.
- LEN: in_ready=1, busy=1.
  - Accepted byte L sets the remaining count N = L, with L=0 meaning N=256.
  - Clear the address counter; go to LOAD.
- LOAD: in_ready=1, busy=1.
  - Byte accepted at edge k: mem_we=1 during cycle k+1, with mem_addr = address counter value before the increment and mem_data = that byte.
  - mem_we is low in every other cycle.
  - The address counter wraps 255->0, which is reachable only with N=256.
  - When the Nth byte is accepted: go to FLUSH, or to CHK when the optional feature is built.
- FLUSH: in_ready=0. Exactly one cycle, covering the final mem_we. Then -> DONE.
- DONE: done=1, cpu_reset=0, busy=0.
  - The core first leaves reset on the edge after the final write has committed.
- ERR: error=1, cpu_reset=1, busy=0. mem_we never asserts in ERR.
- Timeout:
  - An idle counter runs in LEN, LOAD and CHK. It clears on every accepted byte and on state entry.
  - When the counter reaches TIMEOUT, go to ERR on the next edge.
  - If a byte is accepted in the same cycle the counter reaches TIMEOUT, the byte wins and the counter clears.
- start handling:
  - start in DONE or ERR: go to LEN. cpu_reset reasserts in the same cycle the state changes; done and error clear.
  - start in LEN, LOAD, CHK or FLUSH is ignored.
- RESET mid-load returns to IDLE on the next edge. A write already registered for that cycle is dropped, so mem_we=0 after the edge.

Optional Feature:
- Macro: CARREGADOR_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates all payload bytes; it clears in LEN.
  - CHK: in_ready=1, and it also carries the final payload write.
  - The accepted checksum byte C passes if (sum + C) mod 256 == 0: go to DONE on the next edge.
  - Otherwise go to ERR on the next edge.
  - FLUSH is not used.
- Undefined: there is no CHK state and no sum register. LOAD goes to FLUSH and then to DONE.

Test Plan:
- Basic load: RESET, start, stream 03, A1, B2, C3 with in_valid held high.
  - Expect writes (00,A1), (01,B2), (02,C3) on consecutive cycles.
  - done=1 and cpu_reset=0 two cycles after C3 is accepted.
- Backpressure and gaps: same stream with in_valid toggled 1,0,0,1,...
  - Expect exactly 3 writes with correct addresses and no duplicate on held data.
  - in_ready stays 1 throughout.
- Full size and timeout: L=00 followed by 256 bytes, value = index.
  - Expect a last write of (FF,FF), the address counter wrapped to 00, and done=1.
  - With TIMEOUT=8: L=02, one byte, then 8 idle cycles; expect error=1, cpu_reset=1 and no further writes.
- Checksum (CARREGADOR_CHECKSUM_EN): stream 02, 10, 20, D0; expect done=1.
  - Stream 02, 10, 20, D1; expect error=1 and cpu_reset held at 1.
- Restart and reset mid-load:
  - start in DONE: cpu_reset reasserts and a new load at address 00 succeeds.
  - RESET after 2 of 5 payload bytes: IDLE on the next edge with mem_we=0 and all outputs at their reset values.
  - start during LOAD: no effect on count or address.

Source files
------------

// File: rtl/carregador_programa_if.sv
// Byte-stream handshake into the program loader.
// A byte moves on a rising edge where in_valid and in_ready are both high.
interface carregador_programa_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/carregador_programa.sv
// Boot loader: length-prefixed byte stream -> instruction memory from address 0, then releases the core.
// Optional checksum byte after the payload when CARREGADOR_CHECKSUM_EN is defined.
module carregador_programa #(
  parameter int TIMEOUT = 1000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         start,
  carregador_programa_if.slave         s_in,
  output logic                         mem_we,
  output logic [7:0]                   mem_addr,
  output logic [7:0]                   mem_data,
  output logic                         cpu_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
`ifdef CARREGADOR_CHECKSUM_EN
    ST_CHK   = 3'd3,
`endif
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [8:0]  remain_reg, remain_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic        mem_we_reg, mem_we_next;
  logic [7:0]  mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_data_reg, mem_data_next;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  chk_total;
`endif

  logic ready;
  logic accept;
  logic timed_out;
  logic active;

  assign accept    = s_in.in_valid && ready;
  assign timed_out = (TIMEOUT != 0) && (idle_reg == IW'(TIMEOUT));
`ifdef CARREGADOR_CHECKSUM_EN
  assign chk_total = sum_reg + s_in.in_data;
`endif

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= 8'd0;
      remain_reg   <= 9'd0;
      idle_reg     <= '0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= 8'd0;
      mem_data_reg <= 8'd0;
`ifdef CARREGADOR_CHECKSUM_EN
      sum_reg      <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      remain_reg   <= remain_next;
      idle_reg     <= idle_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_data_reg <= mem_data_next;
`ifdef CARREGADOR_CHECKSUM_EN
      sum_reg      <= sum_next;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    remain_next   = remain_reg;
    idle_next     = idle_reg;
    mem_we_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    mem_data_next = mem_data_reg;
`ifdef CARREGADOR_CHECKSUM_EN
    sum_next      = sum_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LEN;
      end
      ST_LEN: begin
`ifdef CARREGADOR_CHECKSUM_EN
        sum_next = 8'd0;
`endif
        if (accept) begin
          // A zero length byte encodes a full 256-byte image
          remain_next = (s_in.in_data == 8'd0) ? 9'd256 : {1'b0, s_in.in_data};
          addr_next   = 8'd0;
          state_next  = ST_LOAD;
        end else if (timed_out) begin
          state_next = ST_ERR;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_next   = 1'b1;
          mem_addr_next = addr_reg;
          mem_data_next = s_in.in_data;
          addr_next     = addr_reg + 8'd1;
          remain_next   = remain_reg - 9'd1;
`ifdef CARREGADOR_CHECKSUM_EN
          sum_next      = sum_reg + s_in.in_data;
          if (remain_reg == 9'd1) state_next = ST_CHK;
`else
          if (remain_reg == 9'd1) state_next = ST_FLUSH;
`endif
        end else if (timed_out) begin
          state_next = ST_ERR;
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_next = (chk_total == 8'd0) ? ST_DONE : ST_ERR;
        end else if (timed_out) begin
          state_next = ST_ERR;
        end
      end
`endif
      ST_FLUSH: begin
        state_next = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_next = ST_LEN;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Idle counter restarts on every byte and on every state change
    if (accept || (state_next != state_reg)) begin
      idle_next = '0;
    end else if ((TIMEOUT != 0) && active) begin
      idle_next = idle_reg + 1'b1;
    end
  end

  // Outputs decoded from the current state only
  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    active    = 1'b0;
    case (state_reg)
      ST_LEN, ST_LOAD: begin
        ready  = 1'b1;
        busy   = 1'b1;
        active = 1'b1;
      end
`ifdef CARREGADOR_CHECKSUM_EN
      ST_CHK: begin
        ready  = 1'b1;
        busy   = 1'b1;
        active = 1'b1;
      end
`endif
      ST_FLUSH: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign s_in.in_ready = ready;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_data      = mem_data_reg;

endmodule
